// File: rtl/add3bit_restore_if.sv
// Handshake bundle for add3bit_restore: upstream diff/b request, downstream result.
// err_cnt exists only when ADD_RESTORE_ERRCNT_EN is defined.
interface add3bit_restore_if #(parameter int WIDTH = 3);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a_out;
  logic             carry_out;
  logic             err;
`ifdef ADD_RESTORE_ERRCNT_EN
  logic [7:0]       err_cnt;

  modport master (output in_valid, diff, b, out_ready,
                  input  in_ready, out_valid, a_out, carry_out, err, err_cnt);
  modport slave  (input  in_valid, diff, b, out_ready,
                  output in_ready, out_valid, a_out, carry_out, err, err_cnt);
`else
  modport master (output in_valid, diff, b, out_ready,
                  input  in_ready, out_valid, a_out, carry_out, err);
  modport slave  (input  in_valid, diff, b, out_ready,
                  output in_ready, out_valid, a_out, carry_out, err);
`endif
endinterface

// File: rtl/add3bit_restore.sv
// Bit-serial restore unit: rebuilds A = S + B from a subtract result {Cout, S} and B.
// Optional saturating error counter enabled by ADD_RESTORE_ERRCNT_EN.
module add3bit_restore #(
  parameter int WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  add3bit_restore_if.slave       bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] b_reg;
  logic             flag;
  logic             c;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic             carry_q;
  logic             err_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             sum_bit;
  logic             carry_next;
  logic             err_next;

  assign sum_bit    = s_reg[idx] ^ b_reg[idx] ^ c;
  assign carry_next = (s_reg[idx] & b_reg[idx]) | (s_reg[idx] & c) | (b_reg[idx] & c);
  // A consistent subtract result has Cout equal to the inverse of the restore carry.
  assign err_next   = (carry_next == flag);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.a_out     = a_q;
  assign bus.carry_out = carry_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s_reg       <= '0;
      b_reg       <= '0;
      flag        <= 1'b0;
      c           <= 1'b0;
      idx         <= '0;
      a_q         <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            s_reg      <= bus.diff[WIDTH-1:0];
            flag       <= bus.diff[WIDTH];
            b_reg      <= bus.b;
            c          <= 1'b0;
            idx        <= '0;
            in_ready_q <= 1'b0;
            state      <= ADD;
          end
        end
        ADD: begin
          a_q[idx] <= sum_bit;
          c        <= carry_next;
          idx      <= idx + 1'b1;
          if (idx == IW'(WIDTH - 1)) begin
            carry_q     <= carry_next;
            err_q       <= err_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // in_ready returns on the same edge out_valid drops, never overlapping.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADD_RESTORE_ERRCNT_EN
  logic [7:0] err_cnt_q;

  assign bus.err_cnt = err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (state == ADD && idx == IW'(WIDTH - 1) && err_next && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_add3bit_restore.sv
// Self-checking bench for add3bit_restore: directed literal cases, random traffic,
// backpressure, busy-input rejection, mid-operation reset and error-counter saturation.
module tb_add3bit_restore;
  localparam int WIDTH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add3bit_restore_if #(.WIDTH(WIDTH)) bus ();
  add3bit_restore #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];
  int exp_cnt = 0;

  // Reference: {err, carry, a} from plain integer addition of S and B.
  function automatic logic [4:0] model(input logic [3:0] d, input logic [2:0] bb);
    int sum;
    logic cy;
    sum = int'(d[2:0]) + int'(bb);
    cy = (sum >= 8);
    return {cy == d[3], cy, 3'(sum % 8)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_out_valid actual=1 required=0 at %0t", $time);
      end else begin
        checkOutput("model_result", {27'd0, bus.err, bus.carry_out, bus.a_out}, {27'd0, exp_q[0]});
      end
      checkOutput("in_ready_while_valid", {31'd0, bus.in_ready}, 32'd0);
`ifdef ADD_RESTORE_ERRCNT_EN
      checkOutput("err_cnt_model", {24'd0, bus.err_cnt}, exp_cnt);
`endif
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && exp_q.size() > 0)
      void'(exp_q.pop_front());
  end

  task automatic applyStimulus(input logic [3:0] d, input logic [2:0] bb);
    int t;
    logic [4:0] m;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.diff = d;
    bus.b = bb;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=%0d required=<50", t);
    end
    @(posedge clk);
    m = model(d, bb);
    exp_q.push_back(m);
    if (m[4] && exp_cnt < 255) exp_cnt++;
    #1;
    bus.in_valid = 1'b0;
    bus.diff = 4'($urandom);
    bus.b = 3'($urandom);
  endtask

  task automatic waitResult(input bit busy_poke, output bit ok);
    int lat;
    ok = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy_poke && i <= 2) begin
        bus.in_valid = 1'b1;
        bus.diff = 4'($urandom);
        bus.b = 3'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        lat = i;
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL result_timeout actual=none required=out_valid within 20 cycles");
    end else begin
      checkOutput("latency", lat, WIDTH + 1);
    end
  endtask

  task automatic releaseResult(input int hold);
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_release", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("out_valid_after_release", {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic runDirected(input string name, input logic [3:0] d, input logic [2:0] bb,
                             input logic [2:0] ea, input logic ec, input logic ee);
    bit ok;
    applyStimulus(d, bb);
    waitResult(1'b1, ok);
    if (ok) begin
      checkOutput({name, "_a"}, {29'd0, bus.a_out}, {29'd0, ea});
      checkOutput({name, "_carry"}, {31'd0, bus.carry_out}, {31'd0, ec});
      checkOutput({name, "_err"}, {31'd0, bus.err}, {31'd0, ee});
    end
    releaseResult(0);
  endtask

  initial begin
    bit ok;
    logic [2:0] s, bb;
    logic cy;
    bus.in_valid = 1'b0;
    bus.diff = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;

    #12;
    checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_a", {29'd0, bus.a_out}, 32'd0);
    checkOutput("reset_carry", {31'd0, bus.carry_out}, 32'd0);
    checkOutput("reset_err", {31'd0, bus.err}, 32'd0);
`ifdef ADD_RESTORE_ERRCNT_EN
    checkOutput("reset_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    runDirected("a5", 4'b1010, 3'd3, 3'd5, 1'b0, 1'b0);
    runDirected("borrow", 4'b0100, 3'd6, 3'd2, 1'b1, 1'b0);
    runDirected("bad_flag", 4'b0100, 3'd3, 3'd7, 1'b0, 1'b1);
`ifdef ADD_RESTORE_ERRCNT_EN
    checkOutput("err_cnt_one", {24'd0, bus.err_cnt}, 32'd1);
`endif
    runDirected("zero", 4'b1000, 3'd0, 3'd0, 1'b0, 1'b0);
    runDirected("max", 4'b0111, 3'd7, 3'd6, 1'b1, 1'b0);

    applyStimulus(4'b1101, 3'd2);
    waitResult(1'b1, ok);
    releaseResult(10);

    applyStimulus(4'b1010, 3'd3);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    checkOutput("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("post_rst_no_output", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    runDirected("after_rst", 4'b1010, 3'd3, 3'd5, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(4'($urandom), 3'($urandom));
      waitResult(n[0], ok);
      releaseResult(int'($urandom_range(0, 3)));
    end

    // Deliberately inconsistent flags drive the error counter into saturation.
    for (int n = 0; n < 260; n++) begin
      s = 3'($urandom);
      bb = 3'($urandom);
      cy = (int'(s) + int'(bb)) >= 8;
      applyStimulus({cy, s}, bb);
      waitResult(1'b0, ok);
      releaseResult(0);
    end
`ifdef ADD_RESTORE_ERRCNT_EN
    checkOutput("err_cnt_saturated", {24'd0, bus.err_cnt}, 32'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add3bit_restore.md
Name: add3bit_restore

Overview:
- Bit-serial restore unit: the inverse of the 3-bit subtract path. It takes a subtract result word {Cout, S} plus the subtrahend B and reconstructs the minuend A = S + B.
- It also checks that the carried-out flag agrees with the reconstruction.
- It sits behind the ALU result bus and is used for operand recovery and self-check of subtract results.
- Valid/ready on both sides; one transaction in flight.

Parameters:
- WIDTH, 3, operand width; diff is WIDTH+1 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  diff/b valid
- in_ready  output  1  unit can accept a transaction
- diff  input  WIDTH+1  subtract result {Cout, S}; Cout=1 means no borrow (A>=B)
- b  input  WIDTH  subtrahend B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- a_out  output  WIDTH  reconstructed A = (S + B) mod 2^WIDTH
- carry_out  output  1  carry out of S + B
- err  output  1  consistency error: carry_out == diff[WIDTH]
- err_cnt  output  8  error count; present only with ADD_RESTORE_ERRCNT_EN

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0.
  - a_out=0, carry_out=0, err=0, internal bit index=0, carry flop=0, err_cnt=0.
  - Reset mid-operation discards the transaction; no output is produced for it.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at a clock edge: capture S=diff[WIDTH-1:0], flag=diff[WIDTH], and b. Clear the carry flop and bit index. Go to ADD.
- ADD:
  - in_ready=0, out_valid=0.
  - Each cycle, for bit i: sum_i = S[i]^b[i]^c, c <= majority(S[i], b[i], c). Write sum_i into a_out[i], then i <= i+1.
  - After bit WIDTH-1: carry_out <= final carry, err <= (final carry == flag), go to DONE.
  - Exactly WIDTH cycles in ADD.
- DONE:
  - out_valid=1; a_out, carry_out and err are held stable.
  - On out_valid && out_ready: go to IDLE, out_valid drops next cycle.
  - in_ready rises in the same cycle out_valid drops; no same-cycle accept and release.
- Latency: acceptance edge at cycle 0; out_valid high from cycle WIDTH+1, i.e. 4 cycles for WIDTH=3.
- Throughput: at most one result per WIDTH+2 cycles when out_ready is held high.
- Arithmetic: unsigned modulo 2^WIDTH.
  - A consistent input has carry_out = ~diff[WIDTH]. If A>=B, S+B=A with no carry; if A<B, S+B=A+2^WIDTH with carry.
  - Any mismatch sets err=1. a_out is still the modular sum.
- Input handling:
  - diff and b are sampled only at the acceptance edge; later changes are ignored.
  - in_valid while busy is ignored; the upstream source holds it.
- Output handling:
  - out_ready low in DONE holds state indefinitely.
  - out_ready outside DONE has no effect.
- a_out bits not yet written during ADD keep their previous values. They are observable only through out_valid, so they are don't-care while out_valid=0.

Optional Feature:
- ADD_RESTORE_ERRCNT_EN defined:
  - Adds the err_cnt output, an 8-bit saturating counter.
  - It increments on the ADD->DONE transition when err is set; it saturates at 255 and is cleared only by reset.
- Not defined: no err_cnt port or counter logic; all other behaviour is identical.

Test Plan:
- Reset, then diff=4'b1010, b=3'd3 (A=5) -> after 4 cycles out_valid=1, a_out=5, carry_out=0, err=0.
- Borrow case: diff=4'b0100, b=3'd6 (A=2) -> a_out=2, carry_out=1, err=0.
- Inconsistent flag: diff=4'b0100, b=3'd3 -> a_out=7, carry_out=0, err=1; err_cnt=1 with ADD_RESTORE_ERRCNT_EN.
- Boundaries: diff=4'b1000, b=0 -> a_out=0, err=0; diff=4'b0111, b=7 -> a_out=6, carry_out=1, err=0.
- Backpressure and busy:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0.
  - in_valid with new data during ADD is ignored.
  - out_ready=1 -> IDLE next cycle, in_ready=1.
- Async reset:
  - Assert rst_n=0 in the 2nd ADD cycle -> immediate out_valid=0, in_ready=1 after release.
  - The next transaction, diff=4'b1010, b=3, returns a_out=5.
- Saturation (ADD_RESTORE_ERRCNT_EN): 260 inconsistent transactions -> err_cnt=255.
